mpu_seq: RTL and testbench

- Sequencer and frame assembler for the MPU-6050 I2C master.
- After reset it waits for sensor power-up, issues the one-shot wake-up (init) transaction, then starts continuous burst reads. It packs each 12-byte burst from register 0x3B into six signed 16-bit words and publishes them with a one-cycle valid strobe.
- A byte watchdog detects a stalled master. On a stall it resets the master and restarts the sequence.
- Sits between the mpu master and the attitude/flight-control datapath.

---
 rtl/mpu_pkg.sv | 14 +
 rtl/mpu_frame_pack.sv | 48 ++++
 rtl/mpu_seq.sv | 119 +++++++++++
 tb/tb_mpu_seq.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared state encodings and frame constants for the MPU-6050 sequencer
package mpu_pkg;
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_STARTUP   = 3'd1,
      ST_INIT_REQ  = 3'd2,
      ST_INIT_WAIT = 3'd3,
      ST_STREAM    = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_t;
   localparam logic [7:0] MPU_REG_BURST = 8'h3B;
   localparam int FRAME_BYTES = 12;
   localparam int AX = 0, AY = 1, AZ = 2, TEMP = 3, GX = 4, GY = 5;
endpackage

// File: rtl/mpu_frame_pack.sv
// mpu_frame_pack: packs burst bytes into big-endian words, published atomically per frame
module mpu_frame_pack
   import mpu_pkg::*;
#(
   parameter int NB = FRAME_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  byte_stb,
   input  logic [7:0]            data,
   output logic                  frame_done,
   output logic                  frame_valid,
   output logic [NB/2-1:0][15:0] words
);
   localparam int IW = $clog2(NB);
   logic [IW-1:0] byte_idx_q, byte_idx_d;
   logic [NB-2:0][7:0] buf_q, buf_d;
   logic [NB-1:0][7:0] full;
   logic [NB/2-1:0][15:0] words_q, words_d;
   logic frame_valid_q;
   always_comb begin
      frame_done = byte_stb && byte_idx_q == IW'(NB - 1);
      byte_idx_d = (clear || frame_done) ? '0 : byte_stb ? byte_idx_q + 1'b1 : byte_idx_q;
      buf_d = buf_q;
      if (byte_stb && !frame_done) buf_d[byte_idx_q] = data;
      // the final byte is taken straight from the input so all words load on the same edge
      full = {data, buf_q};
      words_d = words_q;
      if (frame_done)
         for (int k = 0; k < NB / 2; k++) words_d[k] = {full[2*k], full[2*k+1]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx_q    <= '0;
         buf_q         <= '0;
         words_q       <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         byte_idx_q    <= byte_idx_d;
         buf_q         <= buf_d;
         words_q       <= words_d;
         frame_valid_q <= frame_done;
      end
   end
   assign frame_valid = frame_valid_q;
   assign words       = words_q;
endmodule

// File: rtl/mpu_seq.sv
// mpu_seq: MPU-6050 bring-up, burst streaming and stall recovery sequencer with frame assembly
module mpu_seq
   import mpu_pkg::*;
#(
   parameter int unsigned STARTUP_CYC     = 5000000,
   parameter int unsigned TIMEOUT_CYC     = 50000,
   parameter int unsigned RECOVER_CYC     = 16,
   parameter int unsigned BYTES_PER_FRAME = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        mpu_rst_n,
   output logic        mpu_init,
   output logic        mpu_transfer,
   input  logic        mpu_busy,
   input  logic        mpu_valid,
   input  logic [7:0]  mpu_data,
   output logic        frame_valid,
   output logic [15:0] ax,
   output logic [15:0] ay,
   output logic [15:0] az,
   output logic [15:0] temp,
   output logic [15:0] gx,
   output logic [15:0] gy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  fault_cnt,
   output logic        fault,
   output logic [2:0]  seq_state
);
   seq_state_t state_q, state_d;
   logic [31:0] cnt_q, cnt_d, startup_lim;
   logic recover_q, recover_d, fault_q, fault_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0] fault_cnt_q, fault_cnt_d;
   logic mpu_rst_n_q, mpu_rst_n_d, mpu_init_q, mpu_init_d, mpu_transfer_q, mpu_transfer_d;
   logic in_stream, frame_done, fault_entry;
   logic [5:0][15:0] words;

   assign in_stream = state_q == ST_STREAM;

   mpu_frame_pack #(.NB(BYTES_PER_FRAME)) u_pack (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (!in_stream),
      .byte_stb    (in_stream && mpu_valid),
      .data        (mpu_data),
      .frame_done  (frame_done),
      .frame_valid (frame_valid),
      .words       (words)
   );

   // one counter serves as startup wait, handshake timeout, byte watchdog and recovery hold
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q + 32'd1;
      startup_lim = recover_q ? RECOVER_CYC : STARTUP_CYC;
      case (state_q)
         ST_IDLE:      if (enable) state_d = ST_STARTUP;
         ST_STARTUP:   if (cnt_q == startup_lim - 32'd1) state_d = ST_INIT_REQ;
         ST_INIT_REQ:  if (mpu_busy) state_d = ST_INIT_WAIT;
                       else if (cnt_q == TIMEOUT_CYC - 1) state_d = ST_FAULT;
         ST_INIT_WAIT: if (!mpu_busy) state_d = ST_STREAM;
                       else if (cnt_q == TIMEOUT_CYC - 1) state_d = ST_FAULT;
         ST_STREAM:    if (mpu_valid) cnt_d = '0;
                       else if (cnt_q == TIMEOUT_CYC - 1) state_d = ST_FAULT;
         ST_FAULT:     if (cnt_q == RECOVER_CYC - 1) state_d = ST_STARTUP;
         default:      state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
      if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
      fault_entry = state_d == ST_FAULT && state_q != ST_FAULT;
      recover_d = state_d == ST_FAULT ? 1'b1 : state_d == ST_IDLE ? 1'b0 : recover_q;
      fault_d = fault_entry | (fault_q & ~frame_done);
      fault_cnt_d = (fault_entry && fault_cnt_q != 8'hFF) ? fault_cnt_q + 8'd1 : fault_cnt_q;
      frame_cnt_d = frame_cnt_q + {15'd0, frame_done};
      mpu_rst_n_d = state_d != ST_IDLE && state_d != ST_FAULT;
      mpu_init_d = state_d == ST_INIT_REQ;
      mpu_transfer_d = state_d == ST_STREAM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         recover_q      <= 1'b0;
         fault_q        <= 1'b0;
         frame_cnt_q    <= '0;
         fault_cnt_q    <= '0;
         mpu_rst_n_q    <= 1'b0;
         mpu_init_q     <= 1'b0;
         mpu_transfer_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         recover_q      <= recover_d;
         fault_q        <= fault_d;
         frame_cnt_q    <= frame_cnt_d;
         fault_cnt_q    <= fault_cnt_d;
         mpu_rst_n_q    <= mpu_rst_n_d;
         mpu_init_q     <= mpu_init_d;
         mpu_transfer_q <= mpu_transfer_d;
      end
   end

   assign mpu_rst_n    = mpu_rst_n_q;
   assign mpu_init     = mpu_init_q;
   assign mpu_transfer = mpu_transfer_q;
   assign ax           = words[AX];
   assign ay           = words[AY];
   assign az           = words[AZ];
   assign temp         = words[TEMP];
   assign gx           = words[GX];
   assign gy           = words[GY];
   assign frame_cnt    = frame_cnt_q;
   assign fault_cnt    = fault_cnt_q;
   assign fault        = fault_q;
   assign seq_state    = state_q;
endmodule

// File: tb/tb_mpu_seq.sv
// tb_mpu_seq: randomized self-checking bench for mpu_seq against a byte-queue frame model
`timescale 1ns/1ps
module tb_mpu_seq;
   localparam int SU = 100, TO = 200, RC = 4;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mpu_busy = 1'b0, mpu_valid = 1'b0;
   logic [7:0] mpu_data = 8'h00;
   logic mpu_rst_n, mpu_init, mpu_transfer, frame_valid, fault;
   logic [15:0] ax, ay, az, temp, gx, gy, frame_cnt;
   logic [7:0] fault_cnt;
   logic [2:0] seq_state;
   int checks = 0, errors = 0;
   logic [7:0] mq[$];
   logic [15:0] exp_w[6];
   logic [15:0] exp_frames = 16'd0;
   logic [7:0] exp_faults = 8'd0;
   logic exp_fault = 1'b0;

   always #5 clk = ~clk;

   mpu_seq #(.STARTUP_CYC(SU), .TIMEOUT_CYC(TO), .RECOVER_CYC(RC), .BYTES_PER_FRAME(12)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mpu_rst_n(mpu_rst_n), .mpu_init(mpu_init),
      .mpu_transfer(mpu_transfer), .mpu_busy(mpu_busy), .mpu_valid(mpu_valid), .mpu_data(mpu_data),
      .frame_valid(frame_valid), .ax(ax), .ay(ay), .az(az), .temp(temp), .gx(gx), .gy(gy),
      .frame_cnt(frame_cnt), .fault_cnt(fault_cnt), .fault(fault), .seq_state(seq_state)
   );

   function automatic logic [95:0] words_now();
      return {ax, ay, az, temp, gx, gy};
   endfunction

   function automatic logic [95:0] words_exp();
      return {exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_fault();
      mq.delete();
      exp_fault = 1'b1;
      if (exp_faults != 8'hFF) exp_faults++;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit done);
      mpu_data = b;
      mpu_valid = 1'b1;
      tick();
      mpu_valid = 1'b0;
      mq.push_back(b);
      done = 1'b0;
      if (mq.size() == 12) begin
         for (int k = 0; k < 6; k++) exp_w[k] = {mq[2*k], mq[2*k+1]};
         mq.delete();
         exp_frames++;
         exp_fault = 1'b0;
         done = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b[12], input int maxgap, output bit early, output bit pulsed);
      bit d;
      early = 1'b0;
      pulsed = 1'b0;
      for (int i = 0; i < 12; i++) begin
         send_byte(b[i], d);
         if (d) pulsed = frame_valid;
         else begin
            if (frame_valid) early = 1'b1;
            repeat ($urandom_range(maxgap)) begin
               tick();
               if (frame_valid) early = 1'b1;
            end
         end
      end
   endtask

   task automatic to_stream(output int hi);
      int n;
      n = 0;
      hi = -1;
      for (int i = 0; i < 2000; i++) begin
         if (mpu_init) break;
         if (mpu_rst_n) n++;
         tick();
      end
      if (!mpu_init) return;
      hi = n;
      repeat ($urandom_range(3)) tick();
      mpu_busy = 1'b1;
      tick();
      repeat (4) tick();
      mpu_busy = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({mpu_rst_n, mpu_init, mpu_transfer, frame_valid, fault} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000", {mpu_rst_n, mpu_init, mpu_transfer, frame_valid, fault});
      end
      checks++;
      if ({words_now(), frame_cnt, fault_cnt, seq_state} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h/%h want all zero", words_now(), frame_cnt, fault_cnt, seq_state);
      end
      rst_n = 1'b1;
      repeat (5) tick();
      checks++;
      if ({seq_state, mpu_rst_n} !== {3'd0, 1'b0}) begin
         errors++;
         $display("FAIL idle_park got state %0d rst_n %b want 0 0", seq_state, mpu_rst_n);
      end
   endtask

   task automatic test_bringup();
      int n;
      n = 0;
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (mpu_init) break;
         if (mpu_rst_n) n++;
         tick();
      end
      checks++;
      if (n !== SU) begin
         errors++;
         $display("FAIL startup_len got %0d want %0d", n, SU);
      end
      checks++;
      if ({mpu_init, seq_state} !== {1'b1, 3'd2}) begin
         errors++;
         $display("FAIL init_req got init %b state %0d want 1 2", mpu_init, seq_state);
      end
      repeat (3) tick();
      mpu_busy = 1'b1;
      tick();
      checks++;
      if (mpu_init !== 1'b0) begin
         errors++;
         $display("FAIL init_drop got %b want 0", mpu_init);
      end
      repeat (49) tick();
      checks++;
      if (mpu_transfer !== 1'b0) begin
         errors++;
         $display("FAIL transfer_early got %b want 0", mpu_transfer);
      end
      mpu_busy = 1'b0;
      tick();
      checks++;
      if ({mpu_transfer, seq_state} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL stream_entry got transfer %b state %0d want 1 4", mpu_transfer, seq_state);
      end
   endtask

   task automatic test_frame_pack();
      logic [7:0] b[12];
      bit early, pulsed;
      for (int i = 0; i < 12; i++) b[i] = 8'(i + 1);
      send_frame(b, 2, early, pulsed);
      checks++;
      if ({early, pulsed} !== 2'b01) begin
         errors++;
         $display("FAIL pack_strobe got early %b pulse %b want 0 1", early, pulsed);
      end
      checks++;
      if (words_now() !== 96'h0102_0304_0506_0708_090A_0B0C) begin
         errors++;
         $display("FAIL pack_words got %h want 0102030405060708090a0b0c", words_now());
      end
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL pack_count got %0d want %0d", frame_cnt, exp_frames);
      end
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL strobe_width got %b want 0", frame_valid);
      end
      for (int f = 0; f < 4; f++) begin
         bit d;
         for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
         for (int i = 0; i < 6; i++) send_byte(b[i], d);
         checks++;
         if (words_now() !== words_exp()) begin
            errors++;
            $display("FAIL atomic_words got %h want %h", words_now(), words_exp());
         end
         for (int i = 6; i < 12; i++) send_byte(b[i], d);
         checks++;
         if ({frame_valid, words_now(), frame_cnt} !== {1'b1, words_exp(), exp_frames}) begin
            errors++;
            $display("FAIL rand_frame got %b %h %0d want 1 %h %0d", frame_valid, words_now(), frame_cnt, words_exp(), exp_frames);
         end
         tick();
      end
   endtask

   task automatic test_signed();
      logic [7:0] b[12];
      bit early, pulsed;
      for (int i = 0; i < 12; i++) b[i] = 8'hFF;
      send_frame(b, 1, early, pulsed);
      checks++;
      if ($signed(ax) !== -16'sd1 || words_now() !== words_exp() || !pulsed) begin
         errors++;
         $display("FAIL signed_words got %h pulse %b want %h", words_now(), pulsed, words_exp());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[12];
      bit early, pulsed;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
         send_frame(b, 0, early, pulsed);
         checks++;
         if ({early, pulsed, words_now(), frame_cnt} !== {2'b01, words_exp(), exp_frames}) begin
            errors++;
            $display("FAIL b2b_frame got %b%b %h %0d want 01 %h %0d", early, pulsed, words_now(), frame_cnt, words_exp(), exp_frames);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] b[12];
      bit early, pulsed;
      force dut.frame_cnt_q = 16'hFFFF;
      tick();
      release dut.frame_cnt_q;
      exp_frames = 16'hFFFF;
      for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
      send_frame(b, 1, early, pulsed);
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL frame_wrap got %0d want %0d", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_watchdog();
      logic [7:0] b[12];
      bit d, early, pulsed, seen;
      int n, hi;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), d);
      seen = 1'b0;
      repeat (TO - 1) begin
         tick();
         if (fault) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL wd_early got %b want 0", seen);
      end
      tick();
      model_fault();
      checks++;
      if ({fault, fault_cnt, seq_state, mpu_rst_n, mpu_transfer} !== {exp_fault, exp_faults, 3'd5, 2'b00}) begin
         errors++;
         $display("FAIL wd_fault got %b %0d %0d %b%b want 1 %0d 5 00", fault, fault_cnt, seq_state, mpu_rst_n, mpu_transfer, exp_faults);
      end
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (mpu_rst_n) break;
         n++;
         tick();
      end
      checks++;
      if (n !== RC) begin
         errors++;
         $display("FAIL recover_len got %0d want %0d", n, RC);
      end
      to_stream(hi);
      checks++;
      if (hi !== RC || mpu_transfer !== 1'b1) begin
         errors++;
         $display("FAIL restart got startup %0d transfer %b want %0d 1", hi, mpu_transfer, RC);
      end
      for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
      send_frame(b, 1, early, pulsed);
      checks++;
      if ({pulsed, fault, words_now(), fault_cnt} !== {1'b1, exp_fault, words_exp(), exp_faults}) begin
         errors++;
         $display("FAIL wd_newframe got %b %b %h %0d want 1 %b %h %0d", pulsed, fault, words_now(), fault_cnt, exp_fault, words_exp(), exp_faults);
      end
   endtask

   task automatic test_init_timeout();
      int n;
      bit expired;
      enable = 1'b0;
      tick();
      mq.delete();
      enable = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (mpu_init) break;
         tick();
      end
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (seq_state == 3'd5) break;
         if (mpu_init) n++;
         tick();
      end
      model_fault();
      checks++;
      if (n !== TO || {fault, fault_cnt} !== {exp_fault, exp_faults}) begin
         errors++;
         $display("FAIL init_timeout got %0d cycles fault %b cnt %0d want %0d 1 %0d", n, fault, fault_cnt, TO, exp_faults);
      end
      expired = 1'b0;
      for (int f = 0; f < 260 && !expired; f++) begin
         int w;
         w = 0;
         while (seq_state == 3'd5 && w < 400) begin tick(); w++; end
         while (seq_state != 3'd5 && w < 400) begin tick(); w++; end
         if (w >= 400) expired = 1'b1;
         else model_fault();
      end
      checks++;
      if (expired || fault_cnt !== exp_faults || fault_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL fault_sat got %0d expired %b want %0d", fault_cnt, expired, exp_faults);
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] b[12];
      bit d, early, pulsed;
      int hi;
      enable = 1'b0;
      tick();
      mq.delete();
      checks++;
      if ({seq_state, mpu_rst_n, mpu_init, mpu_transfer, fault, fault_cnt} !== {3'd0, 3'b000, exp_fault, exp_faults}) begin
         errors++;
         $display("FAIL disable got %0d %b%b%b %b %0d want 0 000 %b %0d", seq_state, mpu_rst_n, mpu_init, mpu_transfer, fault, fault_cnt, exp_fault, exp_faults);
      end
      for (int i = 0; i < 3; i++) begin
         mpu_data = 8'($urandom);
         mpu_valid = 1'b1;
         tick();
      end
      mpu_valid = 1'b0;
      enable = 1'b1;
      to_stream(hi);
      checks++;
      if (hi !== SU || mpu_transfer !== 1'b1) begin
         errors++;
         $display("FAIL reenable got startup %0d transfer %b want %0d 1", hi, mpu_transfer, SU);
      end
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), d);
      enable = 1'b0;
      tick();
      mq.delete();
      checks++;
      if ({frame_valid, seq_state, frame_cnt} !== {1'b0, 3'd0, exp_frames}) begin
         errors++;
         $display("FAIL drop_midframe got %b %0d %0d want 0 0 %0d", frame_valid, seq_state, frame_cnt, exp_frames);
      end
      enable = 1'b1;
      to_stream(hi);
      for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
      send_frame(b, 2, early, pulsed);
      checks++;
      if ({early, pulsed, fault, words_now(), frame_cnt} !== {2'b01, exp_fault, words_exp(), exp_frames}) begin
         errors++;
         $display("FAIL realign got %b%b %b %h %0d want 01 %b %h %0d", early, pulsed, fault, words_now(), frame_cnt, exp_fault, words_exp(), exp_frames);
      end
   endtask

   task automatic test_enable_collision();
      bit d;
      for (int i = 0; i < 11; i++) send_byte(8'($urandom), d);
      enable = 1'b0;
      send_byte(8'($urandom), d);
      checks++;
      if ({d, frame_valid, seq_state, words_now(), frame_cnt} !== {2'b11, 3'd0, words_exp(), exp_frames}) begin
         errors++;
         $display("FAIL drop_on_last got %b %0d %h %0d want 1 0 %h %0d", frame_valid, seq_state, words_now(), frame_cnt, words_exp(), exp_frames);
      end
      enable = 1'b1;
   endtask

   task automatic test_async_reset();
      logic [7:0] b[12];
      bit early, pulsed;
      int hi;
      to_stream(hi);
      for (int i = 0; i < 12; i++) b[i] = 8'($urandom_range(255, 1));
      send_frame(b, 1, early, pulsed);
      checks++;
      if ({mpu_transfer, words_now()} !== {1'b1, words_exp()}) begin
         errors++;
         $display("FAIL pre_reset got %b %h want 1 %h", mpu_transfer, words_now(), words_exp());
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mpu_rst_n, mpu_init, mpu_transfer, frame_valid, fault, words_now(), frame_cnt, fault_cnt, seq_state} !== '0) begin
         errors++;
         $display("FAIL async_reset got %b%b%b%b%b %h %0d %0d %0d want all zero", mpu_rst_n, mpu_init, mpu_transfer, frame_valid, fault, words_now(), frame_cnt, fault_cnt, seq_state);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_bringup();
      test_frame_pack();
      test_signed();
      test_back_to_back();
      test_wrap();
      test_watchdog();
      test_init_timeout();
      test_enable_drop();
      test_enable_collision();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
